// File: rtl/i2c_master_burst_ctrl_pkg.sv
// Shared command codes, state encoding and helpers
// for the I2C master burst byte controller.
package i2c_master_burst_ctrl_pkg;

  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WR_BIT = 3'd2,
    ST_WR_ACK = 3'd3,
    ST_RD_BIT = 3'd4,
    ST_RD_ACK = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

  function automatic logic [3:0] state_cmd(input state_e s);
    logic [3:0] c;
    c = I2C_CMD_NOP;
    case (s)
      ST_START:  c = I2C_CMD_START;
      ST_WR_BIT: c = I2C_CMD_WRITE;
      ST_WR_ACK: c = I2C_CMD_READ;
      ST_RD_BIT: c = I2C_CMD_READ;
      ST_RD_ACK: c = I2C_CMD_WRITE;
      ST_STOP:   c = I2C_CMD_STOP;
      default:   c = I2C_CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_master_burst_ctrl_counter.sv
// Bit and byte counters for the burst controller:
// 3-bit wrapping bit counter, byte counter counting down to zero.
module i2c_burst_counter
  import i2c_master_burst_ctrl_pkg::*;
#(
  parameter int LW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          bit_step_i,
  input  logic          byte_step_i,
  input  logic [LW-1:0] len_i,
  output logic          byte_end_o,
  output logic          last_byte_o
);

  logic [2:0]    bit_q;
  logic [LW-1:0] byte_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_q  <= 3'd0;
      byte_q <= '0;
    end else if (load_i) begin
      bit_q  <= 3'd0;
      byte_q <= len_i;
    end else begin
      if (bit_step_i)  bit_q  <= bit_q + 3'd1;
      if (byte_step_i) byte_q <= byte_q - 1'b1;
    end
  end

  assign byte_end_o  = (bit_q == 3'd7);
  assign last_byte_o = (byte_q == '0);

endmodule

// File: rtl/i2c_master_burst_ctrl.sv
// Byte-level I2C master controller: optional START, burst of
// 1..NBYTES read/write bytes with ACK phases, optional STOP.
module i2c_master_burst_ctrl
  import i2c_master_burst_ctrl_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int LW     = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                Stop,
  input  logic                Read,
  input  logic                Write,
  input  logic                Tx_ack,
  input  logic [LW-1:0]       Len,
  input  logic [8*NBYTES-1:0] Din,
  input  logic                Bit_ack,
  input  logic                Bit_rxd,
  input  logic                I2C_al,
  output logic [3:0]          Bit_cmd,
  output logic                Bit_txd,
  output logic [8*NBYTES-1:0] Dout,
  output logic                Rx_ack,
  output logic                Ack_err,
  output logic                Al,
  output logic                I2C_busy,
  output logic                I2C_done
);

  localparam int W = 8 * NBYTES;
  localparam logic [LW-1:0] MAXL = LW'(NBYTES - 1);

  state_e        state_q, state_d;
  state_e        data_st, tail_st, post_start;
  logic [3:0]    cmd_q;
  logic          txd_q;
  logic [W-1:0]  sr_q, dout_q;
  logic          rx_ack_q, ack_err_q, al_q, busy_q, done_q;
  logic          stop_q, read_q, write_q, tx_ack_q;
  logic          acc, ack, bit_step, byte_step;
  logic          byte_end, last_byte, issue_txd;
  logic [LW-1:0] sat_len;

  assign sat_len = (Len > MAXL) ? MAXL : Len;
  assign acc = (state_q == ST_IDLE) & (Start | Stop | Read | Write);
  // A Bit_ack only counts while a command is actually on the bus
  assign ack = (state_q != ST_IDLE) & (cmd_q != I2C_CMD_NOP)
             & Bit_ack & ~I2C_al;

  assign bit_step = ack &
    ((state_q == ST_WR_BIT) | (state_q == ST_RD_BIT));
  assign byte_step = ack & ~last_byte &
    (((state_q == ST_WR_ACK) & ~Bit_rxd) | (state_q == ST_RD_ACK));

  i2c_burst_counter #(.LW(LW)) u_cnt (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .load_i      (acc),
    .bit_step_i  (bit_step),
    .byte_step_i (byte_step),
    .len_i       (sat_len),
    .byte_end_o  (byte_end),
    .last_byte_o (last_byte)
  );

  assign data_st = Write ? ST_WR_BIT :
                   Read  ? ST_RD_BIT :
                   Stop  ? ST_STOP   : ST_IDLE;
  assign tail_st = stop_q ? ST_STOP : ST_IDLE;
  assign post_start = write_q ? ST_WR_BIT :
                      read_q  ? ST_RD_BIT : tail_st;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (acc) state_d = Start ? ST_START : data_st;
      ST_START:
        if (ack) state_d = post_start;
      ST_WR_BIT:
        if (ack && byte_end) state_d = ST_WR_ACK;
      ST_WR_ACK:
        if (ack) state_d = (Bit_rxd || last_byte) ? tail_st : ST_WR_BIT;
      ST_RD_BIT:
        if (ack && byte_end) state_d = ST_RD_ACK;
      ST_RD_ACK:
        if (ack) state_d = last_byte ? tail_st : ST_RD_BIT;
      ST_STOP:
        if (ack) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && I2C_al) state_d = ST_IDLE;
  end

  always_comb begin
    issue_txd = 1'b0;
    unique case (1'b1)
      state_q == ST_WR_BIT: issue_txd = sr_q[W-1];
      state_q == ST_RD_ACK: issue_txd = last_byte & tx_ack_q;
      default:              issue_txd = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= I2C_CMD_NOP;
      txd_q     <= 1'b0;
      sr_q      <= '0;
      dout_q    <= '0;
      rx_ack_q  <= 1'b0;
      ack_err_q <= 1'b0;
      al_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stop_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      tx_ack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (acc) begin
        stop_q    <= Stop;
        write_q   <= Write;
        read_q    <= Read & ~Write;
        tx_ack_q  <= Tx_ack;
        sr_q      <= Din << {MAXL - sat_len, 3'b000};
        rx_ack_q  <= 1'b0;
        ack_err_q <= 1'b0;
        al_q      <= 1'b0;
        busy_q    <= 1'b1;
      end else if (state_q != ST_IDLE) begin
        if (ack) begin
          cmd_q <= I2C_CMD_NOP;
          case (state_q)
            ST_WR_BIT: sr_q <= {sr_q[W-2:0], 1'b0};
            ST_RD_BIT: dout_q <= {dout_q[W-2:0], Bit_rxd};
            ST_WR_ACK: begin
              rx_ack_q <= Bit_rxd;
              if (Bit_rxd && !last_byte) ack_err_q <= 1'b1;
            end
            default: ;
          endcase
        end else if (cmd_q == I2C_CMD_NOP) begin
          cmd_q <= state_cmd(state_q);
          txd_q <= issue_txd;
        end
        if (I2C_al) al_q <= 1'b1;
        if (state_d == ST_IDLE) begin
          cmd_q  <= I2C_CMD_NOP;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign Bit_cmd  = cmd_q;
  assign Bit_txd  = txd_q;
  assign Dout     = dout_q;
  assign Rx_ack   = rx_ack_q;
  assign Ack_err  = ack_err_q;
  assign Al       = al_q;
  assign I2C_busy = busy_q;
  assign I2C_done = done_q;

endmodule

// File: tb/tb_i2c_master_burst_ctrl.sv
// Randomized bench for i2c_master_burst_ctrl with a
// transaction-level model of the expected bit operations.
module tb_i2c_master_burst_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;
  localparam logic [3:0] C_NOP   = 4'b0000;
  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_READ  = 4'b1000;

  typedef struct {
    logic [3:0] cmd;
    logic       txd;
    logic       rxd;
    logic       wack;
    logic       last;
  } op_t;

  logic         Clk, Rst, Start, Stop, Read, Write, Tx_ack;
  logic [1:0]   Len;
  logic [W-1:0] Din;
  logic         Bit_ack, Bit_rxd, I2C_al;
  logic [3:0]   Bit_cmd;
  logic         Bit_txd;
  logic [W-1:0] Dout;
  logic         Rx_ack, Ack_err, Al, I2C_busy, I2C_done;

  int n_checks = 0;
  int n_fail   = 0;

  op_t          ops[$];
  logic [W-1:0] exp_dout, exp_dout_nxt;
  bit           c_start, c_stop, c_read, c_write, c_txack;
  logic [1:0]   c_len;
  logic [W-1:0] c_din;
  logic [7:0]   c_rdata[NB];
  int           c_nack;

  i2c_master_burst_ctrl #(.NBYTES(NB), .LW(2)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop),
    .Read(Read), .Write(Write), .Tx_ack(Tx_ack), .Len(Len),
    .Din(Din), .Bit_ack(Bit_ack), .Bit_rxd(Bit_rxd),
    .I2C_al(I2C_al), .Bit_cmd(Bit_cmd), .Bit_txd(Bit_txd),
    .Dout(Dout), .Rx_ack(Rx_ack), .Ack_err(Ack_err), .Al(Al),
    .I2C_busy(I2C_busy), .I2C_done(I2C_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cmd"}, Bit_cmd, C_NOP);
    check({tag, "_txd"}, Bit_txd, 0);
    check({tag, "_dout"}, Dout, 0);
    check({tag, "_rxack"}, Rx_ack, 0);
    check({tag, "_ackerr"}, Ack_err, 0);
    check({tag, "_al"}, Al, 0);
    check({tag, "_busy"}, I2C_busy, 0);
    check({tag, "_done"}, I2C_done, 0);
  endtask

  // Expected bus operations for the configured command
  task automatic build();
    int n;
    logic [7:0] b;
    ops.delete();
    exp_dout_nxt = exp_dout;
    n = int'(c_len) + 1;
    if (n > NB) n = NB;
    if (c_start) ops.push_back('{C_START, 1'b0, 1'b0, 1'b0, 1'b0});
    if (c_write) begin
      for (int i = 0; i < n; i++) begin
        b = c_din[8*(n-1-i) +: 8];
        for (int j = 7; j >= 0; j--)
          ops.push_back('{C_WRITE, b[j], 1'b0, 1'b0, 1'b0});
        ops.push_back('{C_READ, 1'b0, (i == c_nack), 1'b1, (i == n-1)});
        if (i == c_nack && i != n-1) break;
      end
    end else if (c_read) begin
      for (int i = 0; i < n; i++) begin
        b = c_rdata[i];
        for (int j = 7; j >= 0; j--)
          ops.push_back('{C_READ, 1'b0, b[j], 1'b0, 1'b0});
        exp_dout_nxt = (exp_dout_nxt << 8) | W'(b);
        ops.push_back('{C_WRITE, (i == n-1) ? c_txack : 1'b0,
                        1'b0, 1'b0, 1'b0});
      end
    end
    if (c_stop) ops.push_back('{C_STOP, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic run_cmd(input int al_in, input int rst_at,
                         input bit al_rand);
    int  k = 0, wait_n, exp_n, al_at;
    bit  acked = 0, got_done = 0, aborted = 0;
    logic exp_rx = 0, exp_err = 0;
    build();
    al_at = al_rand ? $urandom_range(0, ops.size() - 1) : al_in;
    exp_n = (al_at >= 0) ? al_at : ops.size();
    for (int i = 0; i < exp_n; i++)
      if (ops[i].wack) begin
        exp_rx = ops[i].rxd;
        if (ops[i].rxd && !ops[i].last) exp_err = 1;
      end
    @(negedge Clk);
    Start = c_start; Stop = c_stop; Read = c_read; Write = c_write;
    Tx_ack = c_txack; Len = c_len; Din = c_din;
    @(negedge Clk);
    Start = 0; Stop = 0; Read = 0; Write = 0;
    check("busy_on_accept", I2C_busy, 1);
    wait_n = $urandom_range(0, 2);
    for (int cyc = 0; cyc < 800 && !got_done && !aborted; cyc++) begin
      @(negedge Clk);
      Bit_ack = 0;
      I2C_al  = 0;
      if (acked) begin
        check("nop_gap", Bit_cmd, C_NOP);
        acked = 0;
      end
      if (I2C_done) got_done = 1;
      else if (Bit_cmd != C_NOP) begin
        if (wait_n > 0) wait_n--;
        else begin
          wait_n = $urandom_range(0, 2);
          if (k >= ops.size()) begin
            check("extra_op", Bit_cmd, C_NOP);
            aborted = 1;
          end else begin
            check("op_cmd", Bit_cmd, ops[k].cmd);
            if (ops[k].cmd == C_WRITE)
              check("op_txd", Bit_txd, ops[k].txd);
            if (k == rst_at) begin
              #2 Rst = 1;
              #1 check_reset_outs("async_rst");
              aborted = 1;
            end else begin
              Bit_ack = 1;
              Bit_rxd = ops[k].rxd;
              acked = 1;
              if (k == al_at) I2C_al = 1;
              else k++;
            end
          end
        end
      end
    end
    if (rst_at >= 0) begin
      exp_dout = '0;
      @(negedge Clk);
      check_reset_outs("rst_hold");
      Rst = 0;
    end else begin
      check("done_seen", got_done, 1);
      if (got_done) begin
        check("busy_at_done", I2C_busy, 0);
        check("op_count", k, exp_n);
        check("rx_ack", Rx_ack, exp_rx);
        check("ack_err", Ack_err, exp_err);
        check("al", Al, (al_at >= 0));
        if (al_at < 0) exp_dout = exp_dout_nxt;
        check("dout", Dout, exp_dout);
        @(negedge Clk);
        check("done_pulse", I2C_done, 0);
        check("idle_cmd", Bit_cmd, C_NOP);
      end
    end
  endtask

  task automatic set_cmd(input bit s, input bit p, input bit r,
                         input bit w, input logic [1:0] l,
                         input logic [W-1:0] d, input bit ta,
                         input int nk);
    c_start = s; c_stop = p; c_read = r; c_write = w;
    c_len = l; c_din = d; c_txack = ta; c_nack = nk;
  endtask

  initial begin
    Rst = 1; Start = 0; Stop = 0; Read = 0; Write = 0; Tx_ack = 0;
    Len = 0; Din = '0; Bit_ack = 0; Bit_rxd = 0; I2C_al = 0;
    exp_dout = '0;
    for (int i = 0; i < NB; i++) c_rdata[i] = 8'h00;
    #3 check_reset_outs("reset");
    repeat (2) @(negedge Clk);
    Rst = 0;

    set_cmd(1, 1, 0, 1, 2'd1, 32'h0000_A55A, 0, -1);
    run_cmd(-1, -1, 0);

    c_rdata[0] = 8'h12; c_rdata[1] = 8'h34; c_rdata[2] = 8'h56;
    set_cmd(1, 1, 1, 0, 2'd2, '0, 1, -1);
    run_cmd(-1, -1, 0);
    check("dout_123456", Dout[23:0], 24'h123456);

    set_cmd(0, 1, 0, 1, 2'd3, 32'h1122_3344, 0, 1);
    run_cmd(-1, -1, 0);
    check("nack_ackerr", Ack_err, 1);

    set_cmd(1, 0, 0, 1, 2'd0, 32'h0000_00F0, 0, -1);
    run_cmd(4, -1, 0);

    set_cmd(0, 1, 0, 0, 2'd0, '0, 0, -1);
    run_cmd(-1, -1, 0);
    check("al_cleared", Al, 0);

    set_cmd(0, 0, 1, 1, 2'd0, 32'h0000_0096, 0, -1);
    run_cmd(-1, -1, 0);

    c_rdata[0] = 8'hC3;
    set_cmd(1, 1, 1, 0, 2'd0, '0, 0, -1);
    run_cmd(-1, 3, 0);

    set_cmd(1, 1, 0, 1, 2'd0, 32'h0000_0081, 0, 0);
    run_cmd(-1, -1, 0);

    for (int t = 0; t < 30; t++) begin
      bit s, p, r, w, ar;
      s = 1'($urandom); p = 1'($urandom);
      r = 1'($urandom); w = 1'($urandom);
      if (!(s | p | r | w)) w = 1;
      for (int i = 0; i < NB; i++) c_rdata[i] = 8'($urandom);
      set_cmd(s, p, r, w, 2'($urandom), W'($urandom), 1'($urandom),
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1);
      ar = w && ($urandom_range(0, 3) == 0);
      run_cmd(-1, -1, ar);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_burst_ctrl.md
Name: i2c_master_burst_ctrl

Overview:
Parametrised next-generation byte-level controller for the I2C master. It executes an optional START, then a burst of 1..NBYTES data bytes (read or write) with a per-byte ACK phase, then an optional STOP, all from one command. It sits between the master register block and the existing bit controller. Its own shift register, bit counter and byte counter replace the external shift register and state timer.

Parameters:
NBYTES, 4, maximum bytes per burst (>=1)
LW, 2, width of Len input; 2**LW >= NBYTES

Ports:
Clk  in  1  master clock
Rst  in  1  asynchronous active-high reset
Start  in  1  generate START before data phase
Stop  in  1  generate STOP after data phase
Read  in  1  data phase reads from slave
Write  in  1  data phase writes to slave
Tx_ack  in  1  ACK(0)/NACK(1) master sends after the last read byte
Len  in  LW  burst length minus one (0 => 1 byte)
Din  in  8*NBYTES  write data; byte Len is sent first, byte 0 last, MSB first
Bit_ack  in  1  one-cycle pulse: bit command complete
Bit_rxd  in  1  received bit, valid with Bit_ack
I2C_al  in  1  arbitration lost (bit controller)
Bit_cmd  out  4  command to bit controller (I2C_CMD_* codes)
Bit_txd  out  1  bit to transmit
Dout  out  8*NBYTES  read data, first received byte in highest used position
Rx_ack  out  1  ACK bit received for the last written byte
Ack_err  out  1  sticky: write burst aborted by slave NACK
Al  out  1  sticky: arbitration lost during the command
I2C_busy  out  1  command in progress
I2C_done  out  1  one-cycle pulse: command finished (normally or aborted)

Behaviour:
- Reset (async, Rst=1): state IDLE, Bit_cmd=NOP, Bit_txd=0, Dout=0, Rx_ack=0, Ack_err=0, Al=0, I2C_busy=0, I2C_done=0; counters and shift register cleared. Rst mid-burst aborts immediately; no STOP is issued.
- All outputs are registered.
- IDLE: a command is accepted on a cycle where any of Start/Stop/Read/Write=1. On acceptance:
  - latch flags, Len and Din;
  - clear Ack_err, Al, Rx_ack;
  - set I2C_busy=1.
- Read and Write both set: Write wins, Read is ignored.
- Neither Read nor Write set: no data phase.
- Phase order: START, then data, then STOP. Absent phases are skipped. If all are absent, the controller returns to IDLE.
- States: IDLE, START, WR_BIT, WR_ACK, RD_BIT, RD_ACK, STOP.
- Command issue: Bit_cmd for a state is driven from the cycle after state entry. It is held until Bit_ack, and returns to NOP on the edge that samples Bit_ack. The next command appears on the following cycle, so each bit operation has one NOP cycle between commands.
- START issues CMD_START. STOP issues CMD_STOP.
- WR_BIT:
  - CMD_WRITE, Bit_txd = shift register MSB.
  - On Bit_ack: shift left and increment the bit counter.
  - After 8 bits, go to WR_ACK.
- WR_ACK:
  - CMD_READ; on Bit_ack, Rx_ack = Bit_rxd.
  - NACK on a non-last byte: set Ack_err=1 and skip the remaining bytes (go to STOP if requested, else IDLE).
  - NACK on the last byte does not set Ack_err.
  - Otherwise: next byte (WR_BIT) or leave the data phase.
- RD_BIT:
  - CMD_READ; on Bit_ack, shift Bit_rxd into the LSB of Dout.
  - Dout shifts continuously, so after Len+1 bytes the first byte occupies bits 8*(Len+1)-1 : 8*Len.
- RD_ACK: CMD_WRITE. Bit_txd = 0 for non-last bytes and Tx_ack for the last byte.
- Counters:
  - The bit counter is 3 bits and wraps 7 -> 0 at byte end.
  - The byte counter counts down from Len; the last byte is when the counter = 0.
  - A Len value above NBYTES-1 is saturated to NBYTES-1.
- Completion: on return to IDLE, I2C_done=1 for exactly one cycle and I2C_busy=0 on the same cycle.
- Command inputs asserted while busy are ignored.
- Arbitration lost: I2C_al=1 in any non-IDLE state forces the following:
  - next state IDLE, Bit_cmd=NOP, Al=1;
  - I2C_done pulse, I2C_busy=0;
  - no STOP is issued.
  - Bit_ack in the same cycle is ignored.
- Bit_ack in IDLE is ignored.

Decomposition:
- Shared defines file holds:
  - I2C_CMD_NOP=4'b0000, I2C_CMD_START=4'b0001, I2C_CMD_STOP=4'b0010, I2C_CMD_WRITE=4'b0100, I2C_CMD_READ=4'b1000;
  - the state encoding localparams.
- One sub-module, i2c_burst_counter, holds the bit counter and byte counter. It has load, bit-step and byte-step inputs and provides byte_end and last_byte flags.

Test Plan:
- Start+Write+Stop, Len=1, Din[15:0]=16'hA55A, slave ACKs every byte:
  - Bit_cmd sequence is START, 8×WRITE (bits 1010_0101), READ, 8×WRITE (0101_1010), READ, STOP;
  - Rx_ack=0, Ack_err=0, one I2C_done pulse.
- Start+Read+Stop, Len=2, Tx_ack=1, slave returns 8'h12, 8'h34, 8'h56:
  - Dout[23:0]=24'h123456;
  - the ACK-phase Bit_txd values are 0, 0, 1.
- Write, Len=3, slave NACKs byte 2 with Stop=1:
  - data phase aborts after 2 bytes, STOP is issued;
  - Ack_err=1, Rx_ack=1, I2C_done pulses.
- Start+Write, I2C_al=1 during the 4th WRITE bit:
  - next cycle Bit_cmd=NOP, Al=1, I2C_done=1, I2C_busy=0, no STOP;
  - a subsequent command clears Al.
- Stop only:
  - single CMD_STOP, Dout unchanged.
  - Read and Write both set with Len=0: a write byte is performed.
- Rst=1 mid-read (3rd bit):
  - all outputs return to reset values asynchronously;
  - after Rst is released, a new Start command is accepted normally.
